mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin memory arbiter with one outstanding transaction
// Optional response timeout is enabled with MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_error,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_error,
    output logic        m1_ready,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_pend;
    logic [1:0]        r_p_instr;
    logic [1:0][31:0]  r_p_addr;
    logic [1:0][31:0]  r_p_wdata;
    logic [1:0][3:0]   r_p_wstrb;
    logic              r_last;
    logic              r_owner;
    logic              r_mem_instr;
    logic [31:0]       r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_wstrb;

    logic [1:0]        w_valid;
    logic [1:0]        w_accept;
    logic              w_grant;
    logic              w_resp;
    logic              w_timeout;
    logic [31:0]       w_rdata;
    logic              w_error;

    assign w_valid = {m1_valid, m0_valid};

    // A port's own response cycle frees it, so a new request in that cycle is taken.
    always_comb begin
        w_accept = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_accept[n] = w_valid[n] && !r_pend[n]
                && !((r_state != S_IDLE) && (r_owner == n[0]) && !w_resp);
        end
    end

    always_comb begin
        w_grant = r_pend[1];
        if (r_pend == 2'b11) begin
            w_grant = ~r_last;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_pend != 2'b00) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_resp) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pend      <= 2'b00;
            r_p_instr   <= '0;
            r_p_addr    <= '0;
            r_p_wdata   <= '0;
            r_p_wstrb   <= '0;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_state <= w_next;
            for (int n = 0; n < 2; n++) begin
                if (w_accept[n]) begin
                    r_pend[n]    <= 1'b1;
                    r_p_instr[n] <= (n == 0) ? m0_instr : m1_instr;
                    r_p_addr[n]  <= (n == 0) ? m0_addr  : m1_addr;
                    r_p_wdata[n] <= (n == 0) ? m0_wdata : m1_wdata;
                    r_p_wstrb[n] <= (n == 0) ? m0_wstrb : m1_wstrb;
                end
            end
            if (r_state == S_IDLE && r_pend != 2'b00) begin
                r_owner     <= w_grant;
                r_last      <= w_grant;
                r_mem_instr <= r_p_instr[w_grant];
                r_mem_addr  <= r_p_addr[w_grant];
                r_mem_wdata <= r_p_wdata[w_grant];
                r_mem_wstrb <= r_p_wstrb[w_grant];
            end
            if (r_state == S_ISSUE) begin
                r_pend[r_owner] <= 1'b0;
            end
        end
    end

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != S_WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt holds completed WAIT cycles, so this fires in the TIMEOUT_CYCLES-th one.
    assign w_timeout = (r_state == S_WAIT) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_resp  = (r_state == S_WAIT) && (mem_ready || w_timeout);
    assign w_rdata = mem_ready ? mem_rdata : 32'h0;
    assign w_error = mem_ready ? mem_error : 1'b1;

    assign m0_ready = w_resp && !r_owner;
    assign m1_ready = w_resp && r_owner;
    assign m0_rdata = m0_ready ? w_rdata : 32'h0;
    assign m1_rdata = m1_ready ? w_rdata : 32'h0;
    assign m0_error = m0_ready && w_error;
    assign m1_error = m1_ready && w_error;

    assign mem_valid = (r_state == S_ISSUE);
    assign mem_instr = r_mem_instr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level model
// Define MEM_ARBITER_TIMEOUT_EN to also exercise the 16-cycle response timeout.
module tb_mem_arbiter;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_valid, m0_instr, m0_error, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_instr, m1_error, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        mem_valid, mem_instr, mem_error, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    mem_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clock(clock), .reset(reset),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_error(m0_error), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_error(m1_error), .m1_ready(m1_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: requests waiting per port, plus the single transaction in flight.
    bit          p_v[2];
    int          p_t[2];
    logic        p_instr[2];
    logic [31:0] p_addr[2], p_wdata[2];
    logic [3:0]  p_wstrb[2];
    bit          busy;
    int          own, issue_c, resp_at, last_g, last_resp, c;
    logic        o_instr;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_wstrb;

    task automatic model_reset();
        p_v[0] = 0; p_v[1] = 0;
        busy = 0; own = 0; resp_at = -1; last_g = 1; last_resp = -100; issue_c = 0;
        o_instr = 0; o_addr = 0; o_wdata = 0; o_wstrb = 0;
    endtask

    task automatic step(input bit v0, input bit v1, input bit spur, input bit rst_in);
        bit          vin[2];
        bit          elig[2];
        bit          resp_now, to_now, exp_issue, acc;
        int          w, lat;
        logic        d_instr[2];
        logic [31:0] d_addr[2], d_wdata[2];
        logic [3:0]  d_wstrb[2];
        logic        e_rdy, e_err;
        logic [31:0] e_data;

        @(posedge clock);
        #1;
        reset = rst_in;
        vin[0] = v0 && !rst_in;
        vin[1] = v1 && !rst_in;
        for (int n = 0; n < 2; n++) begin
            d_instr[n] = 1'($urandom);
            d_addr[n]  = $urandom;
            d_wdata[n] = $urandom;
            d_wstrb[n] = 4'($urandom);
        end
        m0_valid = vin[0]; m0_instr = d_instr[0]; m0_addr = d_addr[0];
        m0_wdata = d_wdata[0]; m0_wstrb = d_wstrb[0];
        m1_valid = vin[1]; m1_instr = d_instr[1]; m1_addr = d_addr[1];
        m1_wdata = d_wdata[1]; m1_wstrb = d_wstrb[1];
        resp_now = !rst_in && busy && (resp_at == c);
        to_now   = TO_EN && !rst_in && busy && !resp_now && (c == issue_c + TO_CYC);
        mem_ready = resp_now || (spur && !busy);
        mem_rdata = $urandom;
        mem_error = ($urandom_range(0, 3) == 0);
        @(negedge clock);

        if (rst_in) begin
            check("rst_ctl", {mem_valid, mem_instr, mem_wstrb, m0_ready, m1_ready, m0_error, m1_error}, 72'h0);
            check("rst_req", {mem_addr, mem_wdata}, 72'h0);
            check("rst_rdata", {m0_rdata, m1_rdata}, 72'h0);
            model_reset();
            c++;
            return;
        end

        // A request captured in cycle t is seen by an idle arbiter in t+1 and issued in t+2;
        // after a response in cycle R the arbiter is idle in R+1 and can issue in R+2.
        for (int n = 0; n < 2; n++) elig[n] = p_v[n] && (p_t[n] <= c - 2);
        exp_issue = !busy && (c >= last_resp + 2) && (elig[0] || elig[1]);
        if (elig[0] && elig[1]) w = (last_g == 1) ? 0 : 1;
        else                    w = elig[1] ? 1 : 0;

        check("mem_valid", {71'h0, mem_valid}, {71'h0, exp_issue});
        if (exp_issue)
            check("mem_req", {3'h0, mem_instr, mem_wstrb, mem_addr, mem_wdata},
                  {3'h0, p_instr[w], p_wstrb[w], p_addr[w], p_wdata[w]});
        else if (busy)
            check("mem_hold", {3'h0, mem_instr, mem_wstrb, mem_addr, mem_wdata},
                  {3'h0, o_instr, o_wstrb, o_addr, o_wdata});

        e_data = resp_now ? mem_rdata : 32'h0;
        e_err  = resp_now ? mem_error : 1'b1;
        e_rdy  = (resp_now || to_now) && (own == 0);
        check("rsp0", {38'h0, m0_ready, m0_error, m0_rdata},
              {38'h0, e_rdy, e_rdy && e_err, e_rdy ? e_data : 32'h0});
        e_rdy  = (resp_now || to_now) && (own == 1);
        check("rsp1", {38'h0, m1_ready, m1_error, m1_rdata},
              {38'h0, e_rdy, e_rdy && e_err, e_rdy ? e_data : 32'h0});

        for (int n = 0; n < 2; n++) begin
            acc = vin[n] && !p_v[n] && !(busy && own == n && !(resp_now || to_now));
            if (acc) begin
                p_v[n] = 1; p_t[n] = c;
                p_instr[n] = d_instr[n]; p_addr[n] = d_addr[n];
                p_wdata[n] = d_wdata[n]; p_wstrb[n] = d_wstrb[n];
            end
        end
        if (resp_now || to_now) begin
            busy = 0; last_resp = c; resp_at = -1;
        end
        if (exp_issue) begin
            busy = 1; own = w; last_g = w; issue_c = c;
            o_instr = p_instr[w]; o_addr = p_addr[w]; o_wdata = p_wdata[w]; o_wstrb = p_wstrb[w];
            p_v[w] = 0;
            lat = (TO_EN && $urandom_range(0, 7) == 0) ? 30 : $urandom_range(1, 4);
            resp_at = c + lat;
        end
        c++;
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        mem_ready = 0; mem_rdata = 0; mem_error = 0;
        c = 0;
        model_reset();

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                step(0, 0, 0, 1);
                step(0, 0, 0, 1);
                step(0, 0, 1, 0);
            end else begin
                step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 9) == 0, 0);
            end
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
